// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the status unit and the branch unit.
//   - Status register bit positions (branch unit indexes status with these).
//   - flag_op encodings for the explicit flag instructions.
//   - Status unit push/pull sequencer states.
package cpu_pkg;

  localparam int C_BIT = 7;
  localparam int Z_BIT = 6;
  localparam int I_BIT = 5;
  localparam int D_BIT = 4;
  localparam int B_BIT = 3;
  localparam int V_BIT = 2;
  localparam int R_BIT = 1;
  localparam int N_BIT = 0;

  typedef enum logic [2:0] {
    FOP_NONE = 3'd0,
    FOP_CLC  = 3'd1,
    FOP_SEC  = 3'd2,
    FOP_CLI  = 3'd3,
    FOP_SEI  = 3'd4,
    FOP_CLD  = 3'd5,
    FOP_SED  = 3'd6,
    FOP_CLV  = 3'd7
  } flag_op_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PUSH      = 2'd1,
    ST_PULL_WAIT = 2'd2
  } state_e;

  // Stored status never holds B and always holds the reserved bit.
  function automatic logic [7:0] stored_form(input logic [7:0] s);
    logic [7:0] r;
    r        = s;
    r[B_BIT] = 1'b0;
    r[R_BIT] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/status_flag_merge.sv
// Combinational next-status from the ALU flag update and the explicit
// flag instruction. flag_op is applied after the ALU update so it wins
// on a shared bit; untouched bits hold.
// Ports:
//   status_i      current status
//   alu_we        apply ALU update
//   alu_mask      per-flag enable {C,Z,V,N} = [3:0]
//   alu_result    ALU result (Z and N source)
//   alu_carry     carry out
//   alu_overflow  overflow out
//   flag_op       explicit flag instruction
//   status_o      merged status (stored form)
module status_flag_merge
  import cpu_pkg::*;
(
  input  logic [7:0] status_i,
  input  logic       alu_we,
  input  logic [3:0] alu_mask,
  input  logic [7:0] alu_result,
  input  logic       alu_carry,
  input  logic       alu_overflow,
  input  logic [2:0] flag_op,
  output logic [7:0] status_o
);

  logic [7:0] s;

  always_comb begin
    s = status_i;
    if (alu_we) begin
      if (alu_mask[3]) s[C_BIT] = alu_carry;
      if (alu_mask[2]) s[Z_BIT] = (alu_result == 8'h00);
      if (alu_mask[1]) s[V_BIT] = alu_overflow;
      if (alu_mask[0]) s[N_BIT] = alu_result[7];
    end
    case (flag_op)
      FOP_CLC: s[C_BIT] = 1'b0;
      FOP_SEC: s[C_BIT] = 1'b1;
      FOP_CLI: s[I_BIT] = 1'b0;
      FOP_SEI: s[I_BIT] = 1'b1;
      FOP_CLD: s[D_BIT] = 1'b0;
      FOP_SED: s[D_BIT] = 1'b1;
      FOP_CLV: s[V_BIT] = 1'b0;
      default: ;
    endcase
    status_o = stored_form(s);
  end

endmodule

// File: rtl/status_unit.sv
// Processor status register owner. Merges ALU/flag instruction updates,
// pushes status onto the data bus (PHP/BRK/IRQ) and pulls it back (PLP/RTI).
// All state changes on the falling edge of clk_2; rst is asynchronous.
// Ports:
//   rst, clk_1, clk_2        reset, phase-1 (bus qualify), phase-2 clocks
//   alu_*                    ALU flag update request
//   flag_op                  CLC/SEC/CLI/SEI/CLD/SED/CLV
//   push_req/brk/sei         start push, B value in pushed byte, set I after
//   pull_req, data_bus       start pull, bus read data
//   status                   live status register
//   data_out, data_out_en    pushed byte and bus drive enable
//   busy, done               sequencer active, one-cycle completion pulse
module status_unit
  import cpu_pkg::*;
#(
  parameter int         PULL_LAT     = 1,
  parameter logic [7:0] RESET_STATUS = 8'h22
) (
  input  logic       rst,
  input  logic       clk_1,
  input  logic       clk_2,
  input  logic       alu_we,
  input  logic [3:0] alu_mask,
  input  logic [7:0] alu_result,
  input  logic       alu_carry,
  input  logic       alu_overflow,
  input  logic [2:0] flag_op,
  input  logic       push_req,
  input  logic       push_brk,
  input  logic       push_sei,
  input  logic       pull_req,
  input  logic [7:0] data_bus,
  output logic [7:0] status,
  output logic [7:0] data_out,
  output logic       data_out_en,
  output logic       busy,
  output logic       done
);

  localparam logic [7:0] RST_VAL  = stored_form(RESET_STATUS);
  localparam logic [1:0] CNT_INIT = 2'(PULL_LAT - 1);

  state_e     state_q, state_d;
  logic [7:0] status_q, status_d, merged;
  logic [7:0] data_out_q, data_out_d;
  logic [1:0] cnt_q, cnt_d;
  logic       sei_q, sei_d;
  logic       done_q, done_d;

  status_flag_merge u_merge (
    .status_i     (status_q),
    .alu_we       (alu_we),
    .alu_mask     (alu_mask),
    .alu_result   (alu_result),
    .alu_carry    (alu_carry),
    .alu_overflow (alu_overflow),
    .flag_op      (flag_op),
    .status_o     (merged)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    status_d   = merged;
    data_out_d = data_out_q;
    sei_d      = sei_q;
    done_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // push wins over a simultaneous pull; the pull is dropped
        if (push_req) begin
          state_d           = ST_PUSH;
          data_out_d        = status_q;
          data_out_d[B_BIT] = push_brk;
          data_out_d[R_BIT] = 1'b1;
          sei_d             = push_sei;
        end else if (pull_req) begin
          state_d = ST_PULL_WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      ST_PUSH: begin
        if (sei_q) status_d[I_BIT] = 1'b1;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      ST_PULL_WAIT: begin
        if (cnt_q == 2'd0) begin
          // captured byte overrides any ALU/flag_op update this edge
          status_d = stored_form(data_bus);
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(negedge clk_2 or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      status_q   <= RST_VAL;
      data_out_q <= 8'h00;
      cnt_q      <= 2'd0;
      sei_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      status_q   <= status_d;
      data_out_q <= data_out_d;
      cnt_q      <= cnt_d;
      sei_q      <= sei_d;
      done_q     <= done_d;
    end
  end

  assign status      = status_q;
  assign data_out    = data_out_q;
  assign data_out_en = clk_1 & (state_q == ST_PUSH);
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;

endmodule

// File: tb/tb_status_unit.sv
module tb_status_unit;

  localparam int         PULL_LAT = 2;
  localparam logic [7:0] RST_EXP  = 8'h22;

  logic       rst, clk_1, clk_2;
  logic       alu_we, alu_carry, alu_overflow;
  logic [3:0] alu_mask;
  logic [7:0] alu_result, data_bus;
  logic [2:0] flag_op;
  logic       push_req, push_brk, push_sei, pull_req;
  logic [7:0] status, data_out;
  logic       data_out_en, busy, done;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  status_unit #(.PULL_LAT(PULL_LAT), .RESET_STATUS(8'h22)) dut (
    .rst(rst), .clk_1(clk_1), .clk_2(clk_2),
    .alu_we(alu_we), .alu_mask(alu_mask), .alu_result(alu_result),
    .alu_carry(alu_carry), .alu_overflow(alu_overflow), .flag_op(flag_op),
    .push_req(push_req), .push_brk(push_brk), .push_sei(push_sei),
    .pull_req(pull_req), .data_bus(data_bus),
    .status(status), .data_out(data_out), .data_out_en(data_out_en),
    .busy(busy), .done(done)
  );

  // Non-overlapping two-phase clocks, period 20: clk_1 high 0..8, clk_2 high 10..18
  initial begin
    clk_1 = 1'b0;
    clk_2 = 1'b0;
    forever begin
      clk_1 = 1'b1; #8;
      clk_1 = 1'b0; #2;
      clk_2 = 1'b1; #8;
      clk_2 = 1'b0; #2;
    end
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Status as a byte; the sequencer as "what operation is outstanding and
  // how many falling edges remain until it completes".
  logic [7:0] m_status, m_push_byte;
  int         m_mode;   // 0 none, 1 push outstanding, 2 pull outstanding
  int         m_rem;    // falling edges left until pull capture
  logic       m_sei, m_done;

  function automatic logic [7:0] canon(input logic [7:0] s);
    return (s & 8'hF7) | 8'h02;
  endfunction

  function automatic logic [7:0] apply_ops(input logic [7:0] s);
    logic [7:0] r;
    r = s;
    if (alu_we) begin
      if (alu_mask[3]) r[7] = alu_carry;
      if (alu_mask[2]) r[6] = (alu_result == 0);
      if (alu_mask[1]) r[2] = alu_overflow;
      if (alu_mask[0]) r[0] = alu_result[7];
    end
    case (flag_op)
      3'd1: r = r & 8'h7F;
      3'd2: r = r | 8'h80;
      3'd3: r = r & 8'hDF;
      3'd4: r = r | 8'h20;
      3'd5: r = r & 8'hEF;
      3'd6: r = r | 8'h10;
      3'd7: r = r & 8'hFB;
      default: ;
    endcase
    return canon(r);
  endfunction

  always @(negedge clk_2 or posedge rst) begin
    if (rst) begin
      m_status <= canon(RST_EXP);
      m_mode   <= 0;
      m_rem    <= 0;
      m_sei    <= 1'b0;
      m_done   <= 1'b0;
    end else if (m_mode == 1) begin
      m_status <= m_sei ? (apply_ops(m_status) | 8'h20) : apply_ops(m_status);
      m_mode   <= 0;
      m_done   <= 1'b1;
    end else if (m_mode == 2) begin
      if (m_rem == 1) begin
        m_status <= canon(data_bus);
        m_mode   <= 0;
        m_done   <= 1'b1;
      end else begin
        m_status <= apply_ops(m_status);
        m_rem    <= m_rem - 1;
        m_done   <= 1'b0;
      end
    end else begin
      m_status <= apply_ops(m_status);
      m_done   <= 1'b0;
      if (push_req) begin
        m_mode      <= 1;
        m_push_byte <= canon(m_status) | (push_brk ? 8'h08 : 8'h00);
        m_sei       <= push_sei;
      end else if (pull_req) begin
        m_mode <= 2;
        m_rem  <= PULL_LAT;
      end
    end
  end

  // Compare while clk_1 is high (bus drive allowed during a push)
  always @(posedge clk_1) begin
    #1;
    if (chk_en) begin
      chk("status", status, m_status);
      chk("busy", {7'b0, busy}, {7'b0, (m_mode != 0)});
      chk("done", {7'b0, done}, {7'b0, m_done});
      chk("data_out_en_hi", {7'b0, data_out_en}, {7'b0, (m_mode == 1)});
      if (m_mode == 1) chk("data_out", data_out, m_push_byte);
    end
  end

  // While clk_1 is low the bus must never be driven
  always @(posedge clk_2) begin
    #1;
    if (chk_en) chk("data_out_en_lo", {7'b0, data_out_en}, 8'h00);
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk_2);
    #1;
  endtask

  task automatic idle_inputs();
    alu_we = 0; alu_mask = 0; alu_result = 8'h01; alu_carry = 0; alu_overflow = 0;
    flag_op = 0; push_req = 0; push_brk = 0; push_sei = 0; pull_req = 0; data_bus = 8'h00;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    #1;
    chk_en = 1;
    repeat (2) step();
    rst = 1'b0;
    step();
    chk("reset status", status, 8'h22);
    chk("reset busy", {7'b0, busy}, 8'h00);
    chk("reset done", {7'b0, done}, 8'h00);

    // full ALU update
    alu_we = 1; alu_mask = 4'b1111; alu_result = 8'h80; alu_carry = 1; alu_overflow = 1;
    step();
    idle_inputs();
    chk("alu all", status, 8'hA7);

    // flag_op beats ALU on C
    alu_we = 1; alu_mask = 4'b1000; alu_carry = 1; flag_op = 3'd1;
    step();
    idle_inputs();
    chk("clc wins", status, 8'h27);
    alu_we = 1; alu_mask = 4'b0100; alu_result = 8'h00;
    step();
    idle_inputs();
    chk("z only", status, 8'h67);

    // reach 8'h83: ALU gives A3, CLI clears I on the same edge
    alu_we = 1; alu_mask = 4'b1111; alu_result = 8'h80; alu_carry = 1; flag_op = 3'd3;
    step();
    idle_inputs();
    chk("to 83", status, 8'h83);

    // push with B and interrupt entry
    push_req = 1; push_brk = 1; push_sei = 1;
    step();
    idle_inputs();
    chk("push busy", {7'b0, busy}, 8'h01);
    chk("push byte", data_out, 8'h8B);
    @(posedge clk_1); #1;
    chk("push en hi", {7'b0, data_out_en}, 8'h01);
    @(posedge clk_2); #1;
    chk("push en lo", {7'b0, data_out_en}, 8'h00);
    step();
    chk("push done", {7'b0, done}, 8'h01);
    chk("push sei", status, 8'hA3);
    step();
    chk("push done clr", {7'b0, done}, 8'h00);

    // pull with latency 2, second request while waiting is ignored
    data_bus = 8'hFF; pull_req = 1;
    step();
    pull_req = 1;
    chk("pull busy", {7'b0, busy}, 8'h01);
    step();
    pull_req = 0;
    chk("pull no early", status, 8'hA3);
    chk("pull no early done", {7'b0, done}, 8'h00);
    step();
    chk("pull capture", status, 8'hF7);
    chk("pull done", {7'b0, done}, 8'h01);
    data_bus = 8'h00;
    step();
    chk("pull 2nd ignored", {7'b0, busy}, 8'h00);

    // push and pull together: push only, B=0 in the byte
    push_req = 1; pull_req = 1; data_bus = 8'h00;
    step();
    idle_inputs();
    chk("both push byte", data_out, 8'hF7);
    step();
    chk("both done", {7'b0, done}, 8'h01);
    repeat (3) step();
    chk("both pull dropped", status, 8'hF7);
    chk("both idle", {7'b0, busy}, 8'h00);

    // reset mid-pull: abort with no capture
    data_bus = 8'h5A; pull_req = 1;
    step();
    pull_req = 0;
    step();
    rst = 1'b1;
    #1;
    chk("rst mid status", status, 8'h22);
    chk("rst mid busy", {7'b0, busy}, 8'h00);
    chk("rst mid done", {7'b0, done}, 8'h00);
    step();
    rst = 1'b0;
    step();
    chk("rst no capture", status, 8'h22);
    chk("rst no done", {7'b0, done}, 8'h00);

    // randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      alu_we       = 1'($urandom_range(0, 1));
      alu_mask     = 4'($urandom);
      alu_result   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      alu_carry    = 1'($urandom);
      alu_overflow = 1'($urandom);
      flag_op      = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'd0;
      push_req     = ($urandom_range(0, 4) == 0);
      push_brk     = 1'($urandom);
      push_sei     = 1'($urandom);
      pull_req     = ($urandom_range(0, 4) == 0);
      data_bus     = 8'($urandom);
      if ($urandom_range(0, 99) == 0) rst = 1'b1;
      step();
      rst = 1'b0;
    end
    idle_inputs();
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
